// File: rtl/seven_segment_mux_n.sv
// Time-multiplexed common-anode 7-segment driver for NUM_DIGITS hex digits with
// dead-time blanking, PWM brightness, leading-zero suppression and per-frame snapshot.
module seven_segment_mux_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 256,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [6:0]                segs,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     sel,
  output logic                      frame_start
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int D_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [D_W-1:0]   D_LAST   = D_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Lit length after the dead time; all-ones brightness gives the full remainder of the slot.
  function automatic logic [31:0] active_len(input logic [BRIGHT_W-1:0] b);
    return (32'(DIGIT_CYCLES - BLANK_CYCLES) * (32'(b) + 32'd1)) >> BRIGHT_W;
  endfunction

  logic [CNT_W-1:0]        r_cnt;
  logic [D_W-1:0]          r_d;
  logic                    r_run;
  logic                    r_frame_start;
  logic [4*NUM_DIGITS-1:0] r_value_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic                    r_blz_sh;
  logic [BRIGHT_W-1:0]     r_bright_sh;

  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_run_z;
  logic                    w_dig_zero;
  logic                    w_suppress;
  logic [31:0]             w_cnt32;
  logic                    w_lit;

  assign w_wrap = (r_cnt == CNT_LAST) && (r_d == D_LAST);

  // r_run keeps every output dark while reset is held, whatever BLANK_CYCLES is.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_d           <= '0;
      r_run         <= 1'b0;
      r_frame_start <= 1'b0;
      r_value_sh    <= '0;
      r_dp_sh       <= '0;
      r_blz_sh      <= 1'b0;
      r_bright_sh   <= '0;
    end else begin
      r_run         <= 1'b1;
      r_frame_start <= w_wrap;
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_d   <= (r_d == D_LAST) ? '0 : r_d + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wrap) begin
        r_value_sh  <= value;
        r_dp_sh     <= dp_in;
        r_blz_sh    <= blank_lz;
        r_bright_sh <= brightness;
      end
    end
  end

  // Walk from the most significant digit down, tracking whether everything so far is blank.
  always_comb begin
    w_nib      = '0;
    w_dp_bit   = 1'b0;
    w_run_z    = 1'b1;
    w_dig_zero = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run_z = w_run_z && (r_value_sh[4*k +: 4] == 4'd0) && !r_dp_sh[k];
      if (r_d == D_W'(k)) begin
        w_nib      = r_value_sh[4*k +: 4];
        w_dp_bit   = r_dp_sh[k];
        w_dig_zero = w_run_z;
      end
    end
    w_suppress = r_blz_sh && (r_d != '0) && w_dig_zero;
    w_cnt32    = 32'(r_cnt);
    w_lit      = r_run && !w_suppress && (w_cnt32 >= 32'(BLANK_CYCLES)) &&
                 ((w_cnt32 - 32'(BLANK_CYCLES)) < active_len(r_bright_sh));
  end

  always_comb begin
    sel  = '1;
    segs = 7'h7F;
    dp   = 1'b1;
    if (w_lit) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        sel[k] = (r_d != D_W'(k));
      end
      segs = hex7(w_nib);
      dp   = !w_dp_bit;
    end
  end

  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_mux_n.sv
// Directed bench for seven_segment_mux_n: a 4-digit instance plus a 1-digit instance
// sharing clock and reset; cyc counts clock edges since the latest reset release.
module tb_seven_segment_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  sel;
  logic        frame_start;

  logic [3:0]  value1;
  logic [0:0]  dp_in1;
  logic        blank_lz1;
  logic [1:0]  brightness1;
  logic [6:0]  segs1;
  logic        dp1;
  logic [0:0]  sel1;
  logic        frame_start1;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seven_segment_mux_n #(
    .NUM_DIGITS(4), .DIGIT_CYCLES(16), .BLANK_CYCLES(4), .BRIGHT_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .segs(segs), .dp(dp), .sel(sel), .frame_start(frame_start)
  );

  seven_segment_mux_n #(
    .NUM_DIGITS(1), .DIGIT_CYCLES(16), .BLANK_CYCLES(4), .BRIGHT_W(2)
  ) u_one (
    .clk(clk), .rst(rst), .value(value1), .dp_in(dp_in1), .blank_lz(blank_lz1),
    .brightness(brightness1), .segs(segs1), .dp(dp1), .sel(sel1), .frame_start(frame_start1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  // Advance to cycle n while loading a fresh random value after every edge.
  task automatic go_to_rand(input int n);
    while (cyc < n) begin
      tick();
      value = 16'($urandom);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h (cyc=%0d)", tag, obs, exp, cyc);
  endtask

  initial begin
    rst = 1'b0; value = 16'h12AF; dp_in = 4'b0000; blank_lz = 1'b0; brightness = 2'd3;
    value1 = 4'h8; dp_in1 = 1'b0; blank_lz1 = 1'b0; brightness1 = 2'd3;

    // Reset state
    tick(); tick();
    chk("rst_sel", sel, 4'hF);
    chk("rst_segs", segs, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_sel1", sel1, 1'b1);
    rst = 1'b1; cyc = 0;

    // First frame: zero shadows, brightness shadow 0 -> digit 0 '0' lit cnt 4..6
    go_to(3);  chk("dead_sel", sel, 4'hF);
    chk("one_dead_sel", sel1, 1'b1);
    go_to(4);  chk("z_sel_c4", sel, 4'b1110);
    chk("z_segs_c4", segs, 7'b1000000);
    chk("z_dp_c4", dp, 1'b1);
    chk("one_z_sel", sel1, 1'b0);
    chk("one_z_segs", segs1, 7'b1000000);
    go_to(6);  chk("z_sel_c6", sel, 4'b1110);
    go_to(7);  chk("z_sel_c7", sel, 4'hF);
    go_to(16); chk("one_fs16", frame_start1, 1'b1);
    chk("fs_not16", frame_start, 1'b0);
    go_to(17); chk("one_fs17", frame_start1, 1'b0);
    go_to(20); chk("z_sel_d1", sel, 4'b1101);
    chk("one_sel20", sel1, 1'b0);
    chk("one_segs20", segs1, 7'b0000000);
    go_to(31); chk("one_sel31", sel1, 1'b0);
    go_to(32); chk("one_fs32", frame_start1, 1'b1);
    go_to(35); chk("one_sel35", sel1, 1'b1);
    go_to(63); chk("fs_63", frame_start, 1'b0);
    go_to(64); chk("fs_64", frame_start, 1'b1);
    chk("sel_64", sel, 4'hF);
    go_to(65); chk("fs_65", frame_start, 1'b0);

    // Second frame shows F,A,2,1 at full brightness
    go_to(68);  chk("F_sel", sel, 4'b1110);
    chk("F_segs", segs, 7'b0001110);
    go_to(79);  chk("F_sel_c15", sel, 4'b1110);
    go_to(80);  chk("d1_dead", sel, 4'hF);
    go_to(84);  chk("A_sel", sel, 4'b1101);
    chk("A_segs", segs, 7'b0001000);
    go_to(100); chk("2_sel", sel, 4'b1011);
    chk("2_segs", segs, 7'b0100100);
    go_to(116); chk("1_sel", sel, 4'b0111);
    chk("1_segs", segs, 7'b1111001);
    go_to(128); chk("fs_128", frame_start, 1'b1);

    // Brightness change mid-frame is deferred to the next frame
    go_to(129); brightness = 2'd0;
    go_to(143); chk("b3_hold_c15", sel, 4'b1110);
    go_to(196); chk("b0_c4", sel, 4'b1110);
    go_to(198); chk("b0_c6", sel, 4'b1110);
    brightness = 2'd1;
    go_to(199); chk("b0_c7", sel, 4'hF);
    go_to(265); chk("b1_c9", sel, 4'b1110);
    go_to(266); chk("b1_c10", sel, 4'hF);

    // Leading-zero suppression
    value = 16'h0070; blank_lz = 1'b1; dp_in = 4'b0000; brightness = 2'd3;
    go_to(324); chk("lz_d0_sel", sel, 4'b1110);
    chk("lz_d0_segs", segs, 7'b1000000);
    go_to(340); chk("lz_d1_sel", sel, 4'b1101);
    chk("lz_d1_segs", segs, 7'b1111000);
    go_to(356); chk("lz_d2_sel", sel, 4'hF);
    chk("lz_d2_dp", dp, 1'b1);
    go_to(372); chk("lz_d3_sel", sel, 4'hF);
    dp_in = 4'b0100;
    go_to(420); chk("lzdp_d2_sel", sel, 4'b1011);
    chk("lzdp_d2_segs", segs, 7'b1000000);
    chk("lzdp_d2_dp", dp, 1'b0);
    go_to(436); chk("lzdp_d3_sel", sel, 4'hF);

    // Value changes every cycle; only the value on the wrap edge is displayed
    dp_in = 4'b0000; blank_lz = 1'b0;
    go_to_rand(447);
    value = 16'h3C5E;
    tick();
    value = 16'($urandom);
    go_to_rand(452); chk("tear_d0", segs, 7'b0000110);
    go_to_rand(468); chk("tear_d1", segs, 7'b0010010);
    go_to_rand(484); chk("tear_d2", segs, 7'b1000110);
    go_to_rand(500); chk("tear_d3", segs, 7'b0110000);
    chk("tear_d3_sel", sel, 4'b0111);
    value = 16'h9999;

    // Reset mid-frame at cnt=9 of digit 2
    go_to(553); chk("pre_rst_sel", sel, 4'b1011);
    chk("pre_rst_segs", segs, 7'b0010000);
    rst = 1'b0;
    tick();
    chk("mr_sel", sel, 4'hF);
    chk("mr_segs", segs, 7'h7F);
    chk("mr_dp", dp, 1'b1);
    chk("mr_fs", frame_start, 1'b0);
    tick();
    chk("mr_sel2", sel, 4'hF);
    chk("mr_fs2", frame_start, 1'b0);
    rst = 1'b1; cyc = 0;
    go_to(3);  chk("ar_dead", sel, 4'hF);
    go_to(4);  chk("ar_sel_c4", sel, 4'b1110);
    chk("ar_segs_c4", segs, 7'b1000000);
    go_to(7);  chk("ar_sel_c7", sel, 4'hF);
    go_to(16); chk("ar_one_fs", frame_start1, 1'b1);
    go_to(63); chk("ar_fs63", frame_start, 1'b0);
    go_to(64); chk("ar_fs64", frame_start, 1'b1);
    go_to(68); chk("ar_d0_9", segs, 7'b0010000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
